// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - arbitrates CPU instruction and data SRAM-like ports onto one memory port
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin contention; default is fixed data priority)
module cpu_sram_arbiter #(
  parameter int TMO_CYC = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Timeout fires in the WAIT cycle whose count would bring the counter to TMO_CYC
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  state_t      state;
  state_t      state_nxt;

  logic        cmd_wr;
  logic [1:0]  cmd_size;
  logic [3:0]  cmd_wstrb;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        owner_data;
  logic [15:0] tmo_cnt;

  logic        in_idle;
  logic        grant_inst;
  logic        grant_data;
  logic        ret_ok;
  logic        tmo_hit;

  assign in_idle = (state == S_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_data;

  // Priority pointer flips away from whichever requester was just granted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_data <= 1'b1;
    end else if (grant_inst || grant_data) begin
      prio_data <= grant_inst;
    end
  end

  assign grant_data = in_idle && data_req && (!inst_req || prio_data);
`else
  assign grant_data = in_idle && data_req;
`endif

  assign grant_inst = in_idle && inst_req && !grant_data;

  // A memory return only counts while waiting; stale returns in IDLE/REQ fall through
  assign ret_ok  = (state == S_WAIT) && mem_data_ok;
  assign tmo_hit = (state == S_WAIT) && !mem_data_ok && (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one transaction in flight, IDLE -> REQ -> WAIT -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (grant_inst || grant_data) state_nxt = S_REQ;
      S_REQ:  if (mem_addr_ok) state_nxt = S_WAIT;
      S_WAIT: if (ret_ok || tmo_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command register and owner: captured only in the IDLE acceptance cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_wr     <= 1'b0;
      cmd_size   <= 2'd0;
      cmd_wstrb  <= 4'd0;
      cmd_addr   <= 32'd0;
      cmd_wdata  <= 32'd0;
      owner_data <= 1'b0;
    end else if (grant_data) begin
      cmd_wr     <= data_wr;
      cmd_size   <= data_size;
      cmd_wstrb  <= data_wstrb;
      cmd_addr   <= data_addr;
      cmd_wdata  <= data_wdata;
      owner_data <= 1'b1;
    end else if (grant_inst) begin
      cmd_wr     <= 1'b0;
      cmd_size   <= 2'd2;
      cmd_wstrb  <= 4'd0;
      cmd_addr   <= inst_addr;
      cmd_wdata  <= 32'd0;
      owner_data <= 1'b0;
    end
  end

  // Timeout counter: zeroed on entry to WAIT, counts WAIT cycles with no return
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= 16'd0;
    end else if ((state == S_REQ) && mem_addr_ok) begin
      tmo_cnt <= 16'd0;
    end else if ((state == S_WAIT) && !mem_data_ok) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Outputs: all forced low while reset is held, memory command visible only in REQ
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_wstrb    = 4'd0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    tmo_err      = 1'b0;
    if (resetn) begin
      inst_addr_ok = grant_inst;
      data_addr_ok = grant_data;
      if (state == S_REQ) begin
        mem_req   = 1'b1;
        mem_wr    = cmd_wr;
        mem_size  = cmd_size;
        mem_wstrb = cmd_wstrb;
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
      end
      inst_data_ok = (ret_ok || tmo_hit) && !owner_data;
      data_data_ok = (ret_ok || tmo_hit) && owner_data;
      inst_rdata   = (ret_ok && !owner_data) ? mem_rdata : 32'd0;
      data_rdata   = (ret_ok && owner_data) ? mem_rdata : 32'd0;
      tmo_err      = tmo_hit;
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb/tb_cpu_sram_arbiter.sv - table-driven self-checking bench for cpu_sram_arbiter
module tb_cpu_sram_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        tmo_err;

  cpu_sram_arbiter #(.TMO_CYC(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rstn;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [1:0]  dsize;
    logic [3:0]  dwstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        maok;
    logic        mdok;
    logic [31:0] mrdata;
  } in_t;

  typedef struct packed {
    logic        iaok;
    logic        daok;
    logic        mreq;
    logic        mwr;
    logic [1:0]  msize;
    logic [3:0]  mwstrb;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        idok;
    logic [31:0] irdata;
    logic        ddok;
    logic [31:0] drdata;
    logic        terr;
  } out_t;

  typedef struct {
    string tag;
    in_t   i;
    out_t  o;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic in_t mk_in(input logic rstn, input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwr, input logic [1:0] dsize,
                                input logic [3:0] dwstrb, input logic [31:0] daddr,
                                input logic [31:0] dwdata, input logic maok, input logic mdok,
                                input logic [31:0] mrdata);
    in_t r;
    r.rstn = rstn;   r.ireq = ireq;     r.iaddr = iaddr;
    r.dreq = dreq;   r.dwr = dwr;       r.dsize = dsize;
    r.dwstrb = dwstrb; r.daddr = daddr; r.dwdata = dwdata;
    r.maok = maok;   r.mdok = mdok;     r.mrdata = mrdata;
    return r;
  endfunction

  function automatic in_t in_mem(input logic maok, input logic mdok, input logic [31:0] mrdata);
    return mk_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, maok, mdok, mrdata);
  endfunction

  function automatic in_t in_inst(input logic [31:0] addr);
    return mk_in(1'b1, 1'b1, addr, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endfunction

  function automatic in_t in_data(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                                  input logic [31:0] addr, input logic [31:0] wdata);
    return mk_in(1'b1, 1'b0, 32'd0, 1'b1, wr, size, wstrb, addr, wdata, 1'b0, 1'b0, 32'd0);
  endfunction

  function automatic out_t o_z();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t o_grant(input logic is_data);
    out_t o;
    o = '0;
    if (is_data) o.daok = 1'b1;
    else o.iaok = 1'b1;
    return o;
  endfunction

  function automatic out_t o_req(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    out_t o;
    o = '0;
    o.mreq = 1'b1; o.mwr = wr; o.msize = size; o.mwstrb = wstrb;
    o.maddr = addr; o.mwdata = wdata;
    return o;
  endfunction

  function automatic out_t o_ret(input logic is_data, input logic [31:0] rdata, input logic terr);
    out_t o;
    o = '0;
    if (is_data) begin
      o.ddok = 1'b1; o.drdata = rdata;
    end else begin
      o.idok = 1'b1; o.irdata = rdata;
    end
    o.terr = terr;
    return o;
  endfunction

  function automatic void add(input string tag, input in_t i, input out_t o);
    vec_t v;
    v.tag = tag; v.i = i; v.o = o;
    tbl.push_back(v);
  endfunction

  task automatic apply(input in_t i);
    resetn      = i.rstn;
    inst_req    = i.ireq;
    inst_addr   = i.iaddr;
    data_req    = i.dreq;
    data_wr     = i.dwr;
    data_size   = i.dsize;
    data_wstrb  = i.dwstrb;
    data_addr   = i.daddr;
    data_wdata  = i.dwdata;
    mem_addr_ok = i.maok;
    mem_data_ok = i.mdok;
    mem_rdata   = i.mrdata;
  endtask

  task automatic check(input string tag, input out_t exp);
    out_t act;
    act.iaok = inst_addr_ok;  act.daok = data_addr_ok;
    act.mreq = mem_req;       act.mwr = mem_wr;        act.msize = mem_size;
    act.mwstrb = mem_wstrb;   act.maddr = mem_addr;    act.mwdata = mem_wdata;
    act.idok = inst_data_ok;  act.irdata = inst_rdata;
    act.ddok = data_data_ok;  act.drdata = data_rdata; act.terr = tmo_err;
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step(input string tag, input in_t i, input out_t o);
    @(posedge clk);
    #1 apply(i);
    @(negedge clk);
    check(tag, o);
  endtask

  initial begin
    logic        rr;
    logic        win_data;
    logic [31:0] rd;

    apply(mk_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));

`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif

    // Reset: outputs low even with requests pending
    add("rst_gate", mk_in(1'b0, 1'b1, 32'h1C000000, 1'b1, 1'b0, 2'd2, 4'd0, 32'h4, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF), o_z());
    add("rst_idle", mk_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0), o_z());

    // Single inst read; first grant right after release
    add("inst_grant", in_inst(32'h1C000000), o_grant(1'b0));
    add("inst_req_hold", mk_in(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0),
        o_req(1'b0, 2'd2, 4'd0, 32'h1C000000, 32'd0));
    add("inst_wait", in_mem(1'b0, 1'b0, 32'd0), o_z());
    add("inst_ret", in_mem(1'b0, 1'b1, 32'h02800C04), o_ret(1'b0, 32'h02800C04, 1'b0));
    add("stale_idle", in_mem(1'b0, 1'b1, 32'h5A5A5A5A), o_z());

    // Store with addr_ok delayed 4 cycles; changed requester inputs must be ignored
    add("st_grant", in_data(1'b1, 2'd2, 4'hF, 32'h00001000, 32'hDEADBEEF), o_grant(1'b1));
    for (int k = 0; k < 4; k++)
      add($sformatf("st_hold%0d", k), mk_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 4'h0, 32'h2000, 32'd0, 1'b0, 1'b0, 32'd0),
          o_req(1'b1, 2'd2, 4'hF, 32'h00001000, 32'hDEADBEEF));
    add("st_accept", mk_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 4'h0, 32'h2000, 32'd0, 1'b1, 1'b0, 32'd0),
        o_req(1'b1, 2'd2, 4'hF, 32'h00001000, 32'hDEADBEEF));
    add("st_ret", in_mem(1'b0, 1'b1, 32'hAAAA5555), o_ret(1'b1, 32'hAAAA5555, 1'b0));
    add("st_after", in_mem(1'b0, 1'b0, 32'd0), o_z());

    // Timeout on 4th WAIT cycle, late return ignored
    add("to_grant", in_data(1'b0, 2'd2, 4'd0, 32'h00000040, 32'd0), o_grant(1'b1));
    add("to_req", in_mem(1'b1, 1'b0, 32'd0), o_req(1'b0, 2'd2, 4'd0, 32'h00000040, 32'd0));
    for (int k = 1; k < TMO; k++)
      add($sformatf("to_wait%0d", k), in_mem(1'b0, 1'b0, 32'h55), o_z());
    add("to_fire", in_mem(1'b0, 1'b0, 32'h55), o_ret(1'b1, 32'd0, 1'b1));
    add("to_late_idle", in_mem(1'b0, 1'b1, 32'h11111111), o_z());
    add("late_grant", in_inst(32'h1C000004), o_grant(1'b0));
    add("late_in_req", in_mem(1'b0, 1'b1, 32'h22222222), o_req(1'b0, 2'd2, 4'd0, 32'h1C000004, 32'd0));
    add("late_accept", in_mem(1'b1, 1'b0, 32'd0), o_req(1'b0, 2'd2, 4'd0, 32'h1C000004, 32'd0));
    add("late_ret", in_mem(1'b0, 1'b1, 32'h12345678), o_ret(1'b0, 32'h12345678, 1'b0));

    // Contention, back-to-back with immediate addr_ok/data_ok: accepts every 3 cycles
    for (int k = 0; k < 4; k++) begin
      win_data = rr ? (k % 2 == 0) : 1'b1;
      rd = 32'hCAFE0000 + 32'(k);
      add($sformatf("ct%0d_grant", k),
          mk_in(1'b1, 1'b1, 32'h1C000100, 1'b1, 1'b1, 2'd1, 4'h3, 32'h200, 32'h0000BEEF, 1'b1, 1'b1, rd), o_grant(win_data));
      add($sformatf("ct%0d_req", k),
          mk_in(1'b1, 1'b1, 32'h1C000100, 1'b1, 1'b1, 2'd1, 4'h3, 32'h200, 32'h0000BEEF, 1'b1, 1'b1, rd),
          win_data ? o_req(1'b1, 2'd1, 4'h3, 32'h200, 32'h0000BEEF) : o_req(1'b0, 2'd2, 4'd0, 32'h1C000100, 32'd0));
      add($sformatf("ct%0d_ret", k),
          mk_in(1'b1, 1'b1, 32'h1C000100, 1'b1, 1'b1, 2'd1, 4'h3, 32'h200, 32'h0000BEEF, 1'b1, 1'b1, rd), o_ret(win_data, rd, 1'b0));
    end

    foreach (tbl[k]) step(tbl[k].tag, tbl[k].i, tbl[k].o);

    // Reset asserted mid-WAIT while a return is presented
    step("ra_grant", in_inst(32'h1C000200), o_grant(1'b0));
    step("ra_req", in_mem(1'b1, 1'b0, 32'd0), o_req(1'b0, 2'd2, 4'd0, 32'h1C000200, 32'd0));
    @(posedge clk);
    #1 apply(in_mem(1'b0, 1'b1, 32'h00000077));
    #2 check("ra_wait_ret", o_ret(1'b0, 32'h00000077, 1'b0));
    @(negedge clk);
    #2 apply(mk_in(1'b0, 1'b1, 32'h1C000000, 1'b1, 1'b0, 2'd2, 4'd0, 32'h4, 32'd0, 1'b1, 1'b1, 32'h00000077));
    #1 check("ra_async_zero", o_z());
    @(negedge clk);
    check("ra_hold_zero", o_z());
    step("ra_post_grant", in_inst(32'h1C000300), o_grant(1'b0));
    step("ra_post_req", in_mem(1'b1, 1'b0, 32'd0), o_req(1'b0, 2'd2, 4'd0, 32'h1C000300, 32'd0));
    step("ra_post_ret", in_mem(1'b0, 1'b1, 32'h00000099), o_ret(1'b0, 32'h00000099, 1'b0));

    // First contended grant after reset goes to data in both builds
    step("rb_reset", mk_in(1'b0, 1'b1, 32'h1C000400, 1'b1, 1'b0, 2'd2, 4'd0, 32'h300, 32'd0, 1'b0, 1'b0, 32'd0), o_z());
    step("rb_grant", mk_in(1'b1, 1'b1, 32'h1C000400, 1'b1, 1'b0, 2'd2, 4'd0, 32'h300, 32'd0, 1'b0, 1'b0, 32'd0), o_grant(1'b1));
    step("rb_req", in_mem(1'b1, 1'b0, 32'd0), o_req(1'b0, 2'd2, 4'd0, 32'h300, 32'd0));
    step("rb_ret", in_mem(1'b0, 1'b1, 32'h00000005), o_ret(1'b1, 32'h00000005, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
